// File: rtl/rominit_pkg.sv
// Shared types and region-map helpers for the multi-region ROM download manager.
package rominit_pkg;

    localparam int unsigned MAX_REGIONS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } rominit_state_t;

    // sizes holds n entries right-aligned, entry 0 in the most significant slot.
    function automatic logic [31:0] region_base(
        input logic [MAX_REGIONS*32-1:0] sizes,
        input int unsigned               n,
        input int unsigned               idx
    );
        logic [31:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < idx; k++) begin
            acc = acc + sizes[(n-1-k)*32 +: 32];
        end
        return acc;
    endfunction

endpackage

// File: rtl/rominit_skid.sv
// One-entry valid/ready holding register for {sel, addr, data}.
module rominit_skid #(
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pass_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [SEL_W-1:0]  in_sel_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [7:0]        in_data_i,
    input  logic              out_ready_i,
    output logic              full_o,
    output logic [SEL_W-1:0]  out_sel_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [7:0]        out_data_o
);

    logic              full_q, full_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              load;

    // pass_i lets a new entry replace the one leaving on the same cycle.
    assign in_ready_o = !full_q || (pass_i && out_ready_i);
    assign load       = in_valid_i && in_ready_o;

    always_comb begin
        full_d = full_q;
        sel_d  = sel_q;
        addr_d = addr_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            sel_d  = in_sel_i;
            addr_d = in_addr_i;
            data_d = in_data_i;
        end else if (out_ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            sel_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            sel_q  <= sel_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_o     = full_q;
    assign out_sel_o  = sel_q;
    assign out_addr_o = addr_q;
    assign out_data_o = data_q;

endmodule

// File: rtl/rominit_multi.sv
// Splits one ioctl download into consecutive ROM regions over a valid/ready port,
// then pads the tail of the last region with FILL_BYTE.
module rominit_multi
    import rominit_pkg::*;
#(
    parameter int unsigned                NUM_REGIONS  = 3,
    parameter int unsigned                ADDR_W       = 17,
    parameter logic [NUM_REGIONS*32-1:0]  REGION_SIZES = {32'd4096, 32'd4096, 32'd0},
    parameter logic [5:0]                 LOAD_INDEX   = 6'd1,
    parameter logic [7:0]                 FILL_BYTE    = 8'hFF
) (
    input  logic                   CLK_SYS,
    input  logic                   RESET,
    input  logic                   IOCTL_DOWNLOAD,
    input  logic [7:0]             IOCTL_INDEX,
    input  logic                   IOCTL_WR,
    input  logic [24:0]            IOCTL_ADDR,
    input  logic [7:0]             IOCTL_DOUT,
    output logic                   IOCTL_WAIT,
    output logic                   ROMINIT_ACTIVE,
    output logic [NUM_REGIONS-1:0] ROMINIT_SEL,
    output logic [ADDR_W-1:0]      ROMINIT_ADDR,
    output logic [7:0]             ROMINIT_DATA,
    output logic                   ROMINIT_VALID,
    input  logic                   ROMINIT_READY,
    output logic [ADDR_W:0]        ROMINIT_CART_LEN,
    output logic                   ROMINIT_ERR
);

    localparam int unsigned              SX_W     = MAX_REGIONS * 32;
    localparam logic [SX_W-1:0]          SIZES_X  = SX_W'(REGION_SIZES);
    localparam logic [NUM_REGIONS-1:0]   LAST_SEL = NUM_REGIONS'(1) << (NUM_REGIONS - 1);
    localparam logic [ADDR_W:0]          ONE_L    = (ADDR_W+1)'(1);

    rominit_state_t state_q, state_d;
    logic [ADDR_W:0] cart_len_q, cart_len_d;
    logic [ADDR_W:0] pad_q, pad_d;
    logic            err_q, err_d;

    logic [32:0]                         addr_x;
    logic [NUM_REGIONS-1:0]              hit;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0]  rel;

    logic                   fill_mode, full, xfer;
    logic                   ld_valid, ld_ready;
    logic [NUM_REGIONS-1:0] ld_sel;
    logic [ADDR_W-1:0]      ld_addr;
    logic [7:0]             ld_data;
    logic                   unused_index_hi;

    assign unused_index_hi = ^IOCTL_INDEX[7:6];
    assign addr_x          = {8'b0, IOCTL_ADDR};

    // The last region is sized by ADDR_W rather than by its REGION_SIZES entry.
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [32:0] BASE = {1'b0, region_base(SIZES_X, NUM_REGIONS, g)};
        localparam logic [32:0] SPAN = (g == NUM_REGIONS - 1) ? (33'd1 << ADDR_W)
                                     : {1'b0, SIZES_X[(NUM_REGIONS-1-g)*32 +: 32]};
        assign hit[g] = (addr_x >= BASE) && (addr_x < BASE + SPAN);
        assign rel[g] = ADDR_W'(addr_x - BASE);
    end

    assign fill_mode = (state_q == ST_FILL);
    assign xfer      = full && ROMINIT_READY;

    always_comb begin
        ld_sel   = hit;
        ld_addr  = '0;
        ld_data  = IOCTL_DOUT;
        ld_valid = (state_q == ST_LOAD) && IOCTL_WR && (|hit);
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            if (hit[r]) ld_addr = ld_addr | rel[r];
        end
        if (fill_mode) begin
            ld_sel   = LAST_SEL;
            ld_addr  = pad_q[ADDR_W-1:0];
            ld_data  = FILL_BYTE;
            ld_valid = !pad_q[ADDR_W];
        end
    end

    rominit_skid #(
        .SEL_W  (NUM_REGIONS),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk_i       (CLK_SYS),
        .rst_i       (RESET),
        .pass_i      (fill_mode),
        .in_valid_i  (ld_valid),
        .in_ready_o  (ld_ready),
        .in_sel_i    (ld_sel),
        .in_addr_i   (ld_addr),
        .in_data_i   (ld_data),
        .out_ready_i (ROMINIT_READY),
        .full_o      (full),
        .out_sel_o   (ROMINIT_SEL),
        .out_addr_o  (ROMINIT_ADDR),
        .out_data_o  (ROMINIT_DATA)
    );

    always_comb begin
        state_d    = state_q;
        cart_len_d = cart_len_q;
        pad_d      = pad_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (IOCTL_DOWNLOAD && (IOCTL_INDEX[5:0] == LOAD_INDEX)) begin
                    state_d    = ST_LOAD;
                    cart_len_d = '0;
                    err_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (IOCTL_WR && !(ld_valid && ld_ready)) err_d = 1'b1;
                if (!IOCTL_DOWNLOAD) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!full) begin
                    pad_d   = cart_len_q;
                    state_d = cart_len_q[ADDR_W] ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (ld_valid && ld_ready) pad_d = pad_q + ONE_L;
                if (xfer && (ROMINIT_ADDR == '1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (xfer && ROMINIT_SEL[NUM_REGIONS-1] && !fill_mode &&
            ({1'b0, ROMINIT_ADDR} + ONE_L > cart_len_q)) begin
            cart_len_d = {1'b0, ROMINIT_ADDR} + ONE_L;
        end
    end

    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cart_len_q <= '0;
            pad_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cart_len_q <= cart_len_d;
            pad_q      <= pad_d;
            err_q      <= err_d;
        end
    end

    assign IOCTL_WAIT       = full;
    assign ROMINIT_VALID    = full;
    assign ROMINIT_ACTIVE   = (state_q == ST_LOAD) || (state_q == ST_DRAIN) || (state_q == ST_FILL);
    assign ROMINIT_CART_LEN = cart_len_q;
    assign ROMINIT_ERR      = err_q;

endmodule

// File: tb/tb_rominit_multi.sv
// Directed bench for rominit_multi with a shrunk region map (64 + 32 + 256 bytes).
module tb_rominit_multi;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 8;

    logic          clk, rst, dl, wr, wait_o, active, valid, ready, err;
    logic [7:0]    idx, dout, data;
    logic [24:0]   addr;
    logic [NR-1:0] sel;
    logic [AW-1:0] raddr;
    logic [AW:0]   cart_len;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_xfer_cyc = 0;
    int done_cyc = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    rominit_multi #(
        .NUM_REGIONS  (NR),
        .ADDR_W       (AW),
        .REGION_SIZES ({32'd64, 32'd32, 32'd0}),
        .LOAD_INDEX   (6'd1),
        .FILL_BYTE    (8'hFF)
    ) dut (
        .CLK_SYS          (clk),
        .RESET            (rst),
        .IOCTL_DOWNLOAD   (dl),
        .IOCTL_INDEX      (idx),
        .IOCTL_WR         (wr),
        .IOCTL_ADDR       (addr),
        .IOCTL_DOUT       (dout),
        .IOCTL_WAIT       (wait_o),
        .ROMINIT_ACTIVE   (active),
        .ROMINIT_SEL      (sel),
        .ROMINIT_ADDR     (raddr),
        .ROMINIT_DATA     (data),
        .ROMINIT_VALID    (valid),
        .ROMINIT_READY    (ready),
        .ROMINIT_CART_LEN (cart_len),
        .ROMINIT_ERR      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid === 1'b1 && ready === 1'b1) begin
            got_q.push_back({13'b0, sel, raddr, data});
            last_xfer_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [31:0] map_rec(input int a);
        if (a < 64)      return {13'b0, 3'b001, 8'(a),      dat(a)};
        else if (a < 96) return {13'b0, 3'b010, 8'(a - 64), dat(a)};
        else             return {13'b0, 3'b100, 8'(a - 96), dat(a)};
    endfunction

    function automatic logic [31:0] pad_rec(input int a);
        return {13'b0, 3'b100, 8'(a), 8'hFF};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] i);
        idx = i;
        dl  = 1'b1;
        tick();
    endtask

    task automatic dl_byte(input int a, input logic [7:0] d);
        int g = 0;
        while (wait_o === 1'b1 && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) check_eq("wait_timeout", g, 0);
        wr   = 1'b1;
        addr = 25'(a);
        dout = d;
        tick();
        wr   = 1'b0;
    endtask

    task automatic end_dl();
        int g = 0;
        dl = 1'b0;
        while (active === 1'b1 && g < 5000) begin
            tick();
            g++;
        end
        if (g >= 5000) check_eq("done_timeout", g, 0);
        done_cyc = cyc;
        tick();
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int g;
        clk = 1'b0; rst = 1'b0; dl = 1'b0; idx = '0; wr = 1'b0;
        addr = '0; dout = '0; ready = 1'b1;
        #2 rst = 1'b1;
        tick(); tick();
        check_eq("rst_active", active, 1'b0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_wait", wait_o, 1'b0);
        check_eq("rst_bus", {sel, raddr, data}, '0);
        check_eq("rst_cartlen", cart_len, '0);
        check_eq("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // 200-byte image: boot, chr, then 104 cart bytes, padded from 104
        got_q.delete();
        start_dl(8'd1);
        check_eq("active_on_accept", active, 1'b1);
        for (int a = 0; a < 200; a++) begin
            dl_byte(a, dat(a));
            exp_q.push_back(map_rec(a));
        end
        for (int a = 104; a < 256; a++) exp_q.push_back(pad_rec(a));
        end_dl();
        check_eq("t1_cartlen", cart_len, 9'd104);
        check_eq("t1_err", err, 1'b0);
        check_eq("t1_active_drop", done_cyc - last_xfer_cyc, 1);
        compare_stream("t1_xfer");

        // Backpressure: hold READY low for 5 cycles after the first capture
        start_dl(8'd1);
        check_eq("cartlen_clear", cart_len, '0);
        ready = 1'b0;
        wr = 1'b1; addr = '0; dout = dat(0);
        tick();
        wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_wait", wait_o, 1'b1);
            check_eq("bp_valid", valid, 1'b1);
            check_eq("bp_hold", {13'b0, sel, raddr, data}, map_rec(0));
            tick();
        end
        ready = 1'b1;
        tick();
        check_eq("bp_wait_fall", wait_o, 1'b0);
        check_eq("bp_valid_fall", valid, 1'b0);
        exp_q.push_back(map_rec(0));
        for (int a = 1; a < 4; a++) begin
            dl_byte(a, dat(a));
            exp_q.push_back(map_rec(a));
        end
        for (int a = 0; a < 256; a++) exp_q.push_back(pad_rec(a));
        end_dl();
        compare_stream("t2_xfer");

        // Foreign index is ignored entirely
        start_dl(8'd2);
        for (int i = 0; i < 8; i++) begin
            wr = (i % 2 == 0);
            addr = 25'(i);
            tick();
            check_eq("idx2_quiet", {active, valid, wait_o}, 3'b000);
        end
        wr = 1'b0; dl = 1'b0;
        tick();
        check_eq("idx2_no_xfer", got_q.size(), 0);

        // Strobe while full: second byte dropped, ERR sticky
        ready = 1'b0;
        start_dl(8'd1);
        wr = 1'b1; addr = 25'd0; dout = 8'h3C;
        tick();
        addr = 25'd1; dout = 8'hC3;
        tick();
        wr = 1'b0;
        check_eq("ovr_err", err, 1'b1);
        check_eq("ovr_first_kept", {13'b0, sel, raddr, data}, {13'b0, 3'b001, 8'd0, 8'h3C});
        ready = 1'b1;
        exp_q.push_back({13'b0, 3'b001, 8'd0, 8'h3C});
        for (int a = 0; a < 256; a++) exp_q.push_back(pad_rec(a));
        end_dl();
        check_eq("cartlen_empty", cart_len, '0);
        check_eq("err_sticky", err, 1'b1);
        compare_stream("t4_xfer");

        // Full image skips padding; one byte past the end flags ERR
        start_dl(8'd1);
        check_eq("err_clear", err, 1'b0);
        for (int a = 0; a < 352; a++) begin
            dl_byte(a, dat(a));
            exp_q.push_back(map_rec(a));
        end
        check_eq("full_no_err", err, 1'b0);
        dl_byte(352, 8'h77);
        check_eq("err_beyond", err, 1'b1);
        end_dl();
        check_eq("full_cartlen", cart_len, 9'd256);
        compare_stream("t5_xfer");

        // Reset in the middle of padding, then restart
        start_dl(8'd1);
        dl = 1'b0;
        g = 0;
        while (!(valid === 1'b1 && raddr == 8'd100) && g < 1000) begin
            tick();
            g++;
        end
        check_eq("fill_reach_100", g < 1000, 1'b1);
        check_eq("fill_cartlen", cart_len, '0);
        #2 rst = 1'b1;
        #1;
        check_eq("async_valid", valid, 1'b0);
        check_eq("async_active", active, 1'b0);
        check_eq("async_bus", {sel, raddr, data}, '0);
        check_eq("async_wait", wait_o, 1'b0);
        for (int a = 0; a < 100; a++) exp_q.push_back(pad_rec(a));
        compare_stream("t6_partial");
        tick();
        rst = 1'b0;
        tick();
        start_dl(8'd1);
        dl_byte(0, dat(0));
        exp_q.push_back(map_rec(0));
        for (int a = 0; a < 256; a++) exp_q.push_back(pad_rec(a));
        end_dl();
        compare_stream("t6_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
